jk_sequencer: RTL and testbench
===============================

Name: jk_sequencer

Overview:
- Controller that drives the J/K inputs and a clock-enable strobe of a downstream JK flip-flop from a small programmable command list.
- Replaces per-module free-running dividers with one prescaler and one step sequencer, so board-level JK/counter demos run scripted patterns at a human-visible rate.
- Sits between board switches/buttons (start, stop, pause, program writes) and the JK flip-flop datapath.

Parameters:
- CLK_DIV, 50_000_000, system clocks per step; legal range ≥ 2; prescaler width $clog2(CLK_DIV).
- DEPTH, 16, command memory entries.
- ADDR_W, 4, index width; must equal $clog2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level, sampled each clk; begins or restarts playback.
- stop  in  1  level; aborts playback, returns to IDLE.
- pause  in  1  level; freezes playback (see Optional Feature).
- loop  in  1  1 = wrap to step 0 after last step; 0 = stop at DONE.
- last_idx  in  ADDR_W  index of final step (sequence length = last_idx+1).
- prog_we  in  1  command write enable.
- prog_addr  in  ADDR_W  command write address.
- prog_cmd  in  2  command: 00 hold, 01 reset (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1).
- j  out  1  J drive to flip-flop.
- k  out  1  K drive to flip-flop.
- ff_en  out  1  one-cycle clock-enable strobe for the flip-flop.
- step  out  ADDR_W  current step index.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, any state): state IDLE, prescaler 0, step 0, all DEPTH command entries 00, j=k=ff_en=busy=done=0.
- Outputs are decoded only from registered state; there is no combinational path from any input to any output.
- j,k = decode(mem[step]) while busy; 0 otherwise.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE: start=1 → RUN, with prescaler 0 and step 0.
- RUN:
  - Prescaler increments each cycle.
  - ff_en=1 exactly in cycles where prescaler == CLK_DIV-1.
  - On that cycle's closing edge, prescaler → 0 and step advances.
  - If step == last_idx: loop=1 → step 0, stay RUN; loop=0 → DONE, step unchanged.
- DONE: done=1, j=k=0; start=1 → RUN from step 0; stop=1 → IDLE with step 0.
- Timing: first ff_en is high during the CLK_DIV-th cycle after the edge that accepted start; step n strobes at cycle (n+1)*CLK_DIV.
- stop=1 in RUN/PAUSE/DONE → IDLE next edge; step 0, prescaler 0, no ff_en in that cycle.
- Priority: stop > start > pause. start while RUN/PAUSE is ignored.
- Program writes: mem[prog_addr] ← prog_cmd on prog_we, only when busy=0; writes while busy are dropped.
- last_idx and loop are sampled at each step boundary. Changing them mid-run takes effect at the next boundary. If last_idx < step, the run continues until step wraps past DEPTH-1 to 0.
- Step wrap from DEPTH-1 is always to 0.

Optional Feature:
- Macro: JK_SEQUENCER_PAUSE_EN.
- Defined:
  - RUN with pause=1 → PAUSE; prescaler and step frozen, ff_en=0, j/k keep the current step's command, busy=1.
  - PAUSE with pause=0 → RUN, resuming the same prescaler count.
  - stop still aborts from PAUSE.
- Undefined: the pause port exists but is ignored; PAUSE is never entered.

Test Plan (CLK_DIV=4, DEPTH=16):
- Reset mid-RUN at step 3 → same-cycle j=k=ff_en=busy=0, step=0, all memory reads 00 on the next run.
- Program mem[0..3]=10,11,01,00, last_idx=3, loop=0, pulse start → ff_en at cycles 4,8,12,16 with (j,k)=(1,0),(1,1),(0,1),(0,0); done=1 from cycle 17; busy=0.
- Same program, loop=1 → step sequence 0,1,2,3,0,1… with ff_en every 4 cycles indefinitely; done stays 0.
- prog_we with addr 0, cmd 01 during RUN → mem[0] unchanged (still 10) on the next pass.
- start and stop both high in RUN at step 2 → IDLE, step=0, no ff_en that cycle.
- With JK_SEQUENCER_PAUSE_EN: pause for 10 cycles at prescaler=2 → no ff_en for 10 cycles, then next ff_en 2 cycles after release; without the macro, pause is ignored and strobes stay every 4 cycles.

Source files
------------

// File: rtl/jk_sequencer_if.sv
// jk_sequencer_if: control, program-write and JK drive signals of the JK step sequencer.
interface jk_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop;
    logic [ADDR_W-1:0] last_idx;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [1:0]        prog_cmd;
    logic              j;
    logic              k;
    logic              ff_en;
    logic [ADDR_W-1:0] step;
    logic              busy;
    logic              done;
    modport master (
        output start, stop, pause, loop, last_idx, prog_we, prog_addr, prog_cmd,
        input  j, k, ff_en, step, busy, done
    );
    modport slave (
        input  start, stop, pause, loop, last_idx, prog_we, prog_addr, prog_cmd,
        output j, k, ff_en, step, busy, done
    );
endinterface

// File: rtl/jk_sequencer.sv
// jk_sequencer: prescaled step sequencer driving J/K and a clock-enable strobe from a command list.
// Define JK_SEQUENCER_PAUSE_EN to honour the pause input; otherwise pause is ignored.
module jk_sequencer #(
    parameter int CLK_DIV = 50_000_000,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4
) (
    input logic           clk,
    input logic           rst,
    jk_sequencer_if.slave sif
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] STEP_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t            state, state_nx;
    logic [PW-1:0]     presc, presc_nx;
    logic [ADDR_W-1:0] step, step_nx;
    logic [1:0]        mem [DEPTH];
    logic              busy, strobe, pause_req;

    assign busy   = state == RUN || state == PAUSE;
    assign strobe = state == RUN && presc == PRE_LAST;

`ifdef JK_SEQUENCER_PAUSE_EN
    assign pause_req = sif.pause;
`else
    logic unused_pause;
    assign unused_pause = sif.pause;
    assign pause_req    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            presc <= '0;
            step  <= '0;
        end else begin
            state <= state_nx;
            presc <= presc_nx;
            step  <= step_nx;
        end
    end

    // A pause arriving on a strobe cycle still completes that step boundary.
    always_comb begin
        state_nx = state;
        presc_nx = presc;
        step_nx  = step;
        if (sif.stop) begin
            state_nx = IDLE;
            presc_nx = '0;
            step_nx  = '0;
        end else if ((state == IDLE || state == DONE) && sif.start) begin
            state_nx = RUN;
            presc_nx = '0;
            step_nx  = '0;
        end else if (strobe) begin
            presc_nx = '0;
            if (step == sif.last_idx && !sif.loop) begin
                state_nx = DONE;
            end else begin
                step_nx  = (step == sif.last_idx || step == STEP_LAST) ? '0 : step + 1'b1;
                state_nx = pause_req ? PAUSE : RUN;
            end
        end else if (state == RUN) begin
            state_nx = pause_req ? PAUSE : RUN;
            presc_nx = pause_req ? presc : presc + 1'b1;
        end else if (state == PAUSE && !pause_req) begin
            state_nx = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (sif.prog_we && !busy) begin
            mem[sif.prog_addr] <= sif.prog_cmd;
        end
    end

    // Command bits are {J,K} directly.
    assign sif.j     = busy & mem[step][1];
    assign sif.k     = busy & mem[step][0];
    assign sif.ff_en = strobe;
    assign sif.step  = step;
    assign sif.busy  = busy;
    assign sif.done  = state == DONE;
endmodule

// File: tb/tb_jk_sequencer.sv
// tb_jk_sequencer: randomized scoreboard bench for jk_sequencer with CLK_DIV=4, DEPTH=16.
module tb_jk_sequencer;
    localparam int CD = 4;
`ifdef JK_SEQUENCER_PAUSE_EN
    localparam int PD = 11;
    localparam int MID_STEP = 1;
`else
    localparam int PD = 0;
    localparam int MID_STEP = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_sequencer_if #(.ADDR_W(4)) sif ();
    jk_sequencer #(.CLK_DIV(CD), .DEPTH(16), .ADDR_W(4)) dut (.clk(clk), .rst(rst), .sif(sif));

    typedef struct {
        int         cyc;
        int         step;
        logic [1:0] jk;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    logic [1:0] mem_m [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected step event.
    always @(negedge clk) begin
        if (!rst && sif.ff_en) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_cyc", cyc, e.cyc);
                check("strobe_step", sif.step, e.step);
                check("strobe_jk", {sif.j, sif.k}, e.jk);
            end
        end
    end

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic write_cmd(int addr, logic [1:0] cmd);
        sif.prog_we   = 1'b1;
        sif.prog_addr = 4'(addr);
        sif.prog_cmd  = cmd;
        @(negedge clk);
        sif.prog_we = 1'b0;
    endtask

    task automatic program_mem(bit nonzero);
        for (int i = 0; i < 16; i++) begin
            mem_m[i] = 2'(nonzero ? $urandom_range(1, 3) : $urandom_range(0, 3));
            write_cmd(i, mem_m[i]);
        end
    endtask

    // Strobe k of a run started at s lands at s+(k+1)*CD, shifted by delay from index shift_from on.
    task automatic push(int s, int last, int n, int shift_from, int delay);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            x.step = i % (last + 1);
            x.cyc  = s + (i + 1) * CD + (i >= shift_from ? delay : 0);
            x.jk   = mem_m[x.step];
            sb.push_back(x);
        end
    endtask

    task automatic pulse_start();
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
    endtask

    task automatic halt();
        sif.stop = 1'b1;
        @(negedge clk);
        sif.stop = 1'b0;
    endtask

    task automatic run_once(int last);
        int s;
        sif.loop     = 1'b0;
        sif.last_idx = 4'(last);
        s = cyc;
        push(s, last, last + 1, 99, 0);
        pulse_start();
        wait_until(s + (last + 1) * CD + 1);
        check("done_after_run", sif.done, 1);
        check("busy_after_run", sif.busy, 0);
        check("jk_in_done", {sif.j, sif.k}, 0);
        check("step_in_done", sif.step, last);
        check("sb_drained", sb.size(), 0);
        halt();
        check("done_after_stop", sif.done, 0);
        check("step_after_stop", sif.step, 0);
    endtask

    initial begin
        int s, last, n;
        sif.start = 0; sif.stop = 0; sif.pause = 0; sif.loop = 0;
        sif.last_idx = 0; sif.prog_we = 0; sif.prog_addr = 0; sif.prog_cmd = 0;
        repeat (3) @(negedge clk);
        check("rst_j", sif.j, 0);
        check("rst_k", sif.k, 0);
        check("rst_ff_en", sif.ff_en, 0);
        check("rst_busy", sif.busy, 0);
        check("rst_done", sif.done, 0);
        check("rst_step", sif.step, 0);
        rst = 1'b0;
        @(negedge clk);

        mem_m[0] = 2'b10; mem_m[1] = 2'b11; mem_m[2] = 2'b01; mem_m[3] = 2'b00;
        for (int i = 0; i < 4; i++) write_cmd(i, mem_m[i]);
        run_once(3);

        repeat (4) begin
            program_mem(1'b0);
            run_once($urandom_range(0, 15));
        end

        // Looping run; a write during RUN must be dropped.
        program_mem(1'b0);
        last = $urandom_range(1, 5);
        n = 2 * (last + 1) + 1;
        sif.loop = 1'b1;
        sif.last_idx = 4'(last);
        s = cyc;
        push(s, last, n, n, 0);
        pulse_start();
        wait_until(s + 6);
        write_cmd(0, ~mem_m[0]);
        wait_until(s + n * CD + 2);
        check("loop_done_low", sif.done, 0);
        check("loop_busy", sif.busy, 1);
        halt();
        check("loop_stop_busy", sif.busy, 0);
        check("loop_stop_step", sif.step, 0);
        check("loop_stop_ff_en", sif.ff_en, 0);
        check("loop_sb_drained", sb.size(), 0);

        // start and stop together at step 2: stop wins.
        program_mem(1'b0);
        sif.loop = 1'b0;
        sif.last_idx = 4'd5;
        s = cyc;
        push(s, 5, 2, 99, 0);
        pulse_start();
        wait_until(s + 10);
        sif.start = 1'b1;
        sif.stop = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        sif.stop = 1'b0;
        check("ss_busy", sif.busy, 0);
        check("ss_step", sif.step, 0);
        check("ss_ff_en", sif.ff_en, 0);
        check("ss_done", sif.done, 0);
        check("ss_sb_drained", sb.size(), 0);

        // Pause for 10 cycles at prescaler 2 of step 1.
        program_mem(1'b0);
        sif.last_idx = 4'd3;
        s = cyc;
        push(s, 3, 4, 1, PD);
        pulse_start();
        wait_until(s + 7);
        sif.pause = 1'b1;
        wait_until(s + 12);
        check("pause_busy", sif.busy, 1);
        check("pause_step", sif.step, MID_STEP);
        check("pause_jk", {sif.j, sif.k}, mem_m[MID_STEP]);
        wait_until(s + 17);
        sif.pause = 1'b0;
        wait_until(s + 4 * CD + PD + 1);
        check("pause_done", sif.done, 1);
        check("pause_sb_drained", sb.size(), 0);
        halt();

        // Asynchronous reset mid-run at step 3 clears state and the command memory.
        program_mem(1'b1);
        sif.last_idx = 4'd7;
        s = cyc;
        push(s, 7, 3, 99, 0);
        pulse_start();
        wait_until(s + 14);
        rst = 1'b1;
        #1;
        check("arst_j", sif.j, 0);
        check("arst_k", sif.k, 0);
        check("arst_ff_en", sif.ff_en, 0);
        check("arst_busy", sif.busy, 0);
        check("arst_step", sif.step, 0);
        check("arst_sb_drained", sb.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mem_m[i] = 2'b00;
        @(negedge clk);
        run_once(3);

        check("final_sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
